// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - duty-cycle, direction and conflict capture for an H-bridge PWM pair
//
// Purpose: samples the left/right bridge drive lines through 2-flop synchronisers,
//          accumulates their high-cycle counts over a free-running window of PERIOD
//          clocks and, on the last edge of each window, presents the dominant count,
//          the dominant line and whether both lines were ever high together.
// Ports:
//   clk_10k        in   system clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   pwml, pwmr     in   left/right drive lines (asynchronous)
//   speed_meas     out  high-cycle count of the dominant line, 0..PERIOD
//   direction_meas out  1 = left dominant, 0 = right dominant
//   meas_valid     out  one-cycle pulse with each new result
//   conflict       out  both lines high together at least once in the last window

module pwm_capture #(
    parameter int PERIOD = 101,
    parameter int CW     = 8
) (
    input  logic          clk_10k,
    input  logic          rst_n,
    input  logic          pwml,
    input  logic          pwmr,
    output logic [CW-1:0] speed_meas,
    output logic          direction_meas,
    output logic          meas_valid,
    output logic          conflict
);

    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);
    localparam logic [CW-1:0] PMAX = CW'(PERIOD);

    logic          l_meta_q, l_sync_q;
    logic          r_meta_q, r_sync_q;
    logic [CW-1:0] win_cnt_q, win_cnt_d;
    logic [CW-1:0] hi_l_q, hi_l_d;
    logic [CW-1:0] hi_r_q, hi_r_d;
    logic          conf_q, conf_d;
    logic [CW-1:0] speed_q, speed_d;
    logic          dir_q, dir_d;
    logic          valid_q, valid_d;
    logic          conflict_q, conflict_d;

    logic          end_win;
    logic [CW-1:0] hi_l_inc, hi_r_inc;
    logic          conf_inc;

    // Synchronisers: only the second stage is used downstream.
    always_ff @(posedge clk_10k or negedge rst_n) begin
        if (!rst_n) begin
            l_meta_q <= 1'b0;
            l_sync_q <= 1'b0;
            r_meta_q <= 1'b0;
            r_sync_q <= 1'b0;
        end else begin
            l_meta_q <= pwml;
            l_sync_q <= l_meta_q;
            r_meta_q <= pwmr;
            r_sync_q <= r_meta_q;
        end
    end

    always_comb begin
        end_win = (win_cnt_q == LAST);

        // Counts including this edge's sample; saturation can only trigger if PERIOD is misconfigured.
        hi_l_inc = (l_sync_q && (hi_l_q != PMAX)) ? hi_l_q + 1'b1 : hi_l_q;
        hi_r_inc = (r_sync_q && (hi_r_q != PMAX)) ? hi_r_q + 1'b1 : hi_r_q;
        conf_inc = conf_q | (l_sync_q & r_sync_q);

        win_cnt_d  = end_win ? '0 : win_cnt_q + 1'b1;
        hi_l_d     = end_win ? '0 : hi_l_inc;
        hi_r_d     = end_win ? '0 : hi_r_inc;
        conf_d     = end_win ? 1'b0 : conf_inc;

        speed_d    = speed_q;
        dir_d      = dir_q;
        conflict_d = conflict_q;
        valid_d    = end_win;
        if (end_win) begin
            speed_d    = (hi_l_inc > hi_r_inc) ? hi_l_inc : hi_r_inc;
            conflict_d = conf_inc;
            // Equal counts (including an idle bridge) keep the previous direction.
            if (hi_l_inc > hi_r_inc) begin
                dir_d = 1'b1;
            end else if (hi_r_inc > hi_l_inc) begin
                dir_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_10k or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt_q  <= '0;
            hi_l_q     <= '0;
            hi_r_q     <= '0;
            conf_q     <= 1'b0;
            speed_q    <= '0;
            dir_q      <= 1'b0;
            valid_q    <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            win_cnt_q  <= win_cnt_d;
            hi_l_q     <= hi_l_d;
            hi_r_q     <= hi_r_d;
            conf_q     <= conf_d;
            speed_q    <= speed_d;
            dir_q      <= dir_d;
            valid_q    <= valid_d;
            conflict_q <= conflict_d;
        end
    end

    assign speed_meas     = speed_q;
    assign direction_meas = dir_q;
    assign meas_valid     = valid_q;
    assign conflict       = conflict_q;

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - directed self-checking bench for pwm_capture

`timescale 1ns/1ps

module tb_pwm_capture;

    localparam int PERIOD = 101;
    localparam int CW     = 8;

    logic          clk_10k = 1'b0;
    logic          rst_n;
    logic          pwml;
    logic          pwmr;
    logic [CW-1:0] speed_meas;
    logic          direction_meas;
    logic          meas_valid;
    logic          conflict;

    int total  = 0;
    int passed = 0;
    int edge_cnt = 0;

    pwm_capture #(.PERIOD(PERIOD), .CW(CW)) dut (
        .clk_10k        (clk_10k),
        .rst_n          (rst_n),
        .pwml           (pwml),
        .pwmr           (pwmr),
        .speed_meas     (speed_meas),
        .direction_meas (direction_meas),
        .meas_valid     (meas_valid),
        .conflict       (conflict)
    );

    always #5 clk_10k = ~clk_10k;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present one input sample, advance one edge, then check the valid pulse position.
    task automatic tick(input logic l, input logic r);
        pwml = l;
        pwmr = r;
        @(posedge clk_10k);
        #1;
        edge_cnt++;
        check("meas_valid_timing", int'(meas_valid), int'((edge_cnt % PERIOD) == 0));
    endtask

    // One full window of stimulus; modes:
    // 0 left held high, 1 left 49/101, 2 right 30/101, 3 both low, 4 mode 1 plus one both-high cycle
    task automatic run_win(input int mode, input bit chk,
                           input int exp_speed, input int exp_dir, input int exp_conf);
        logic l, r;
        for (int i = 0; i < PERIOD; i++) begin
            l = 1'b0;
            r = 1'b0;
            case (mode)
                0: l = 1'b1;
                1: l = (((i + 37) % PERIOD) < 49);
                2: r = (((i + 11) % PERIOD) < 30);
                4: begin
                    l = (((i + 37) % PERIOD) < 49) || (i == 60);
                    r = (i == 60);
                end
                default: ;
            endcase
            tick(l, r);
        end
        if (chk) begin
            check("speed_meas", int'(speed_meas), exp_speed);
            check("direction_meas", int'(direction_meas), exp_dir);
            check("conflict", int'(conflict), exp_conf);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        pwml  = 1'b0;
        pwmr  = 1'b0;
        #12;
        check("reset_speed", int'(speed_meas), 0);
        check("reset_dir", int'(direction_meas), 0);
        check("reset_valid", int'(meas_valid), 0);
        check("reset_conflict", int'(conflict), 0);
        @(posedge clk_10k);
        #1;
        rst_n    = 1'b1;
        edge_cnt = 0;

        // Left held high: full-scale speed, left dominant.
        run_win(0, 1'b0, 0, 0, 0);
        run_win(0, 1'b1, 101, 1, 0);
        run_win(0, 1'b1, 101, 1, 0);

        // Left 49/101 at arbitrary phase.
        run_win(1, 1'b0, 0, 0, 0);
        run_win(1, 1'b1, 49, 1, 0);
        run_win(1, 1'b1, 49, 1, 0);

        // One both-high cycle mid-window, then a clean window.
        run_win(4, 1'b1, 50, 1, 1);
        run_win(1, 1'b1, 49, 1, 0);

        // Right 30/101, then idle keeps direction 0.
        run_win(2, 1'b0, 0, 0, 0);
        run_win(2, 1'b1, 30, 0, 0);
        run_win(3, 1'b0, 0, 0, 0);
        run_win(3, 1'b1, 0, 0, 0);

        // Left dominant, then idle keeps direction 1.
        run_win(0, 1'b0, 0, 0, 0);
        run_win(0, 1'b1, 101, 1, 0);
        run_win(3, 1'b0, 0, 0, 0);
        run_win(3, 1'b1, 0, 1, 0);
        run_win(3, 1'b1, 0, 1, 0);

        // Mid-window asynchronous reset with non-zero outputs.
        run_win(0, 1'b0, 0, 0, 0);
        run_win(0, 1'b1, 101, 1, 0);
        for (int i = 0; i < 40; i++) begin
            tick(1'b1, 1'b0);
        end
        check("pre_reset_speed", int'(speed_meas), 101);
        check("pre_reset_dir", int'(direction_meas), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_speed", int'(speed_meas), 0);
        check("async_reset_dir", int'(direction_meas), 0);
        check("async_reset_valid", int'(meas_valid), 0);
        check("async_reset_conflict", int'(conflict), 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_10k);
        end
        #1;
        rst_n    = 1'b1;
        edge_cnt = 0;
        run_win(0, 1'b0, 0, 0, 0);
        run_win(0, 1'b1, 101, 1, 0);
        run_win(1, 1'b0, 0, 0, 0);
        run_win(1, 1'b1, 49, 1, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
